// File: rtl/astep_lane_pkg.sv
// Shared types for the lane interrupt arbiter: lane index width, lane ceiling and FSM states.
package astep_lane_pkg;

  localparam int unsigned LANES_MAX = 20;

  typedef logic [4:0] lane_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGrant,
    StBusy
  } lane_state_e;

endpackage

// File: rtl/lane_irq_arbiter_if.sv
// Grant handshake between the lane arbiter (master) and the SPI readout engine (slave).
interface lane_irq_arbiter_if;
  import astep_lane_pkg::*;

  logic      grant_valid;
  logic      grant_ready;
  lane_idx_t grant_lane;
  logic      readout_done;

  modport master (
    output grant_valid,
    output grant_lane,
    input  grant_ready,
    input  readout_done
  );

  modport slave (
    input  grant_valid,
    input  grant_lane,
    output grant_ready,
    output readout_done
  );

endinterface

// File: rtl/lane_rr_pick.sv
// Combinational round-robin search: first set request strictly after rr_ptr_i, wrapping to 0.
module lane_rr_pick
  import astep_lane_pkg::*;
#(
  parameter int unsigned LANES = 20
) (
  input  logic [LANES-1:0] req_i,
  input  lane_idx_t        rr_ptr_i,
  output logic             found_o,
  output lane_idx_t        idx_o
);

  always_comb begin
    lane_idx_t cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // k = LANES revisits rr_ptr_i itself last, so a lone request on it is still served
    for (int unsigned k = 1; k <= LANES; k++) begin
      cand = lane_idx_t'((32'(rr_ptr_i) + k) % LANES);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/lane_irq_arbiter.sv
// Round-robin interrupt arbiter: synchronises per-row interrupts, holds one row, grants it to
// the readout engine and releases it on readout_done or watchdog expiry.
module lane_irq_arbiter
  import astep_lane_pkg::*;
#(
  parameter int unsigned LANES       = 20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_SETTLE = 4
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [LANES-1:0]   lane_interruptn,
  input  logic [LANES-1:0]   lane_enable,
  input  logic [15:0]        timeout_cycles,
  output logic [LANES-1:0]   lane_hold,
  lane_irq_arbiter_if.master grant_if,
  output logic [LANES-1:0]   irq_pending,
  output logic               timeout_event,
  output logic [15:0]        timeout_count
);

  logic [LANES-1:0] sync_q [SYNC_STAGES];
  logic [LANES-1:0] pend_q;
  lane_state_e      state_q, state_d;
  logic [LANES-1:0] hold_q, hold_d;
  lane_idx_t        lane_q, lane_d;
  lane_idx_t        rr_ptr_q, rr_ptr_d;
  logic [15:0]      settle_q, settle_d;
  logic [15:0]      busy_q, busy_d;
  logic [15:0]      tcount_q, tcount_d;
  logic             tevent_q, tevent_d;
  logic             block_q, block_d;
  logic             pick_found;
  lane_idx_t        pick_idx;
  logic             expire;

  // Synchroniser idles high so a reset never looks like a pending interrupt
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      pend_q <= '0;
    end else begin
      sync_q[0] <= lane_interruptn;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      pend_q <= ~sync_q[SYNC_STAGES-1] & lane_enable;
    end
  end

  lane_rr_pick #(
    .LANES (LANES)
  ) u_pick (
    .req_i    (pend_q),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  assign expire = (timeout_cycles != 16'd0) && (busy_q == timeout_cycles);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lane_d   = lane_q;
    rr_ptr_d = rr_ptr_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    tcount_d = tcount_q;
    tevent_d = 1'b0;
    block_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // block_q keeps one quiet IDLE cycle after every release
        if (pick_found && !block_q) begin
          lane_d   = pick_idx;
          settle_d = 16'(HOLD_SETTLE - 1);
          state_d  = StSettle;
          for (int unsigned i = 0; i < LANES; i++) hold_d[i] = (pick_idx == lane_idx_t'(i));
        end
      end
      StSettle: begin
        if (!lane_enable[lane_q]) begin
          hold_d  = '0;
          state_d = StIdle;
        end else if (settle_q == 16'd0) begin
          state_d = StGrant;
        end else begin
          settle_d = settle_q - 16'd1;
        end
      end
      StGrant: begin
        if (!lane_enable[lane_q]) begin
          hold_d  = '0;
          state_d = StIdle;
        end else if (grant_if.grant_ready) begin
          busy_d  = 16'd1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (grant_if.readout_done || expire) begin
          hold_d   = '0;
          rr_ptr_d = lane_q;
          block_d  = 1'b1;
          state_d  = StIdle;
          // A done in the expiry cycle wins: no event, no count
          if (!grant_if.readout_done) begin
            tevent_d = 1'b1;
            if (tcount_q != 16'hFFFF) tcount_d = tcount_q + 16'd1;
          end
        end else begin
          busy_d = busy_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      lane_q   <= '0;
      rr_ptr_q <= lane_idx_t'(LANES - 1);
      settle_q <= '0;
      busy_q   <= '0;
      tcount_q <= '0;
      tevent_q <= 1'b0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      lane_q   <= lane_d;
      rr_ptr_q <= rr_ptr_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      tcount_q <= tcount_d;
      tevent_q <= tevent_d;
      block_q  <= block_d;
    end
  end

  assign lane_hold            = hold_q;
  assign grant_if.grant_valid = (state_q == StGrant);
  assign grant_if.grant_lane  = lane_q;
  assign irq_pending          = pend_q;
  assign timeout_event        = tevent_q;
  assign timeout_count        = tcount_q;

endmodule
